// File: rtl/fantasticfft_ifft8_stream.sv
// Streaming 8-point radix-2 DIT inverse FFT with 1/8 output scaling.
// Samples load in bit-reversed order, one shared butterfly runs 12 times
// in place, and results stream out in natural order.
module fantasticfft_ifft8_stream #(
  parameter int DATA_W = 8,
  parameter int TW_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_re_i,
  input  logic signed [DATA_W-1:0] in_im_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] out_re_o,
  output logic signed [DATA_W-1:0] out_im_o,
  output logic [2:0]               out_idx_o,
  output logic                     out_last_o
);

  // 0.7071 in Q1.(TW_W-2); 45 at TW_W=8
  localparam int CINT   = int'(0.70710678 * real'(1 << (TW_W - 2)));
  localparam int SH     = TW_W - 2;
  localparam int PROD_W = DATA_W + TW_W + 2;
  localparam int PW     = DATA_W + 1;
  localparam int SUM_W  = DATA_W + 2;
  localparam logic signed [PROD_W-1:0] C_EXT   = PROD_W'(CINT);
  localparam logic signed [PROD_W-1:0] ROUND_K = PROD_W'(2 ** (TW_W - 3));
  localparam logic [3:0] LAST_STEP = 4'd12;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [3:0]               step_q, step_d;
  logic signed [DATA_W-1:0] memRe_q [8];
  logic signed [DATA_W-1:0] memIm_q [8];

  logic [1:0]               stage, bfly, twk;
  logic [2:0]               topIdx, botIdx, loadIdx;
  logic                     doButterfly;
  logic signed [DATA_W-1:0] topRe, topIm, botRe, botIm;
  logic signed [PROD_W-1:0] botReX, botImX, prodDiff, prodSum;
  logic signed [DATA_W:0]   rndDiff, rndSum, rndNegSum;
  logic signed [DATA_W:0]   pRe, pIm;
  logic signed [SUM_W-1:0]  addRe, addIm, subRe, subIm;
  logic signed [DATA_W-1:0] newTopRe, newTopIm, newBotRe, newBotIm;

  // step 0..11 are butterflies (stage = step/4); step 12 is a drain cycle
  assign stage       = step_q[3:2];
  assign bfly        = step_q[1:0];
  assign doButterfly = (state_q == COMPUTE) && (step_q != LAST_STEP);
  assign loadIdx     = {cnt_q[0], cnt_q[1], cnt_q[2]};

  // butterfly pair addresses and twiddle index for the current step
  always_comb begin
    topIdx = 3'd0;
    botIdx = 3'd0;
    twk    = 2'd0;
    case (stage)
      2'd0: begin
        topIdx = {bfly, 1'b0};
        botIdx = {bfly, 1'b1};
        twk    = 2'd0;
      end
      2'd1: begin
        topIdx = {bfly[1], 1'b0, bfly[0]};
        botIdx = {bfly[1], 1'b1, bfly[0]};
        twk    = {bfly[0], 1'b0};
      end
      2'd2: begin
        topIdx = {1'b0, bfly};
        botIdx = {1'b1, bfly};
        twk    = bfly;
      end
      default: begin
        topIdx = 3'd0;
        botIdx = 3'd0;
        twk    = 2'd0;
      end
    endcase
  end

  assign topRe = memRe_q[topIdx];
  assign topIm = memIm_q[topIdx];
  assign botRe = memRe_q[botIdx];
  assign botIm = memIm_q[botIdx];

  // (C,C)*x and (-C,C)*x share C*(re-im) and C*(re+im), rounded half-up
  assign botReX    = PROD_W'(botRe);
  assign botImX    = PROD_W'(botIm);
  assign prodDiff  = (botReX - botImX) * C_EXT;
  assign prodSum   = (botReX + botImX) * C_EXT;
  assign rndDiff   = PW'((prodDiff + ROUND_K) >>> SH);
  assign rndSum    = PW'((prodSum + ROUND_K) >>> SH);
  assign rndNegSum = PW'((-prodSum + ROUND_K) >>> SH);

  // select the inverse-twiddle product W^-k * mem[bot]
  always_comb begin
    pRe = PW'(botRe);
    pIm = PW'(botIm);
    case (twk)
      2'd0: begin
        pRe = PW'(botRe);
        pIm = PW'(botIm);
      end
      2'd1: begin
        pRe = rndDiff;
        pIm = rndSum;
      end
      2'd2: begin
        pRe = -PW'(botIm);
        pIm = PW'(botRe);
      end
      default: begin
        pRe = rndNegSum;
        pIm = rndDiff;
      end
    endcase
  end

  assign addRe    = SUM_W'(topRe) + SUM_W'(pRe);
  assign addIm    = SUM_W'(topIm) + SUM_W'(pIm);
  assign subRe    = SUM_W'(topRe) - SUM_W'(pRe);
  assign subIm    = SUM_W'(topIm) - SUM_W'(pIm);
  assign newTopRe = DATA_W'(addRe >>> 1);
  assign newTopIm = DATA_W'(addIm >>> 1);
  assign newBotRe = DATA_W'(subRe >>> 1);
  assign newBotIm = DATA_W'(subIm >>> 1);

  // state, sample counter and butterfly step registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // next-state logic: LOAD counts inputs, COMPUTE steps, UNLOAD counts outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    case (state_q)
      LOAD: begin
        if (in_valid_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = COMPUTE;
            step_d  = 4'd0;
          end
        end
      end
      COMPUTE: begin
        if (step_q == LAST_STEP) begin
          state_d = UNLOAD;
          cnt_d   = 3'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      UNLOAD: begin
        if (out_ready_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 3'd0;
        step_d  = 4'd0;
      end
    endcase
  end

  // sample memory: bit-reversed writes on load, in-place butterfly updates
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        memRe_q[i] <= '0;
        memIm_q[i] <= '0;
      end
    end else if (state_q == LOAD && in_valid_i) begin
      memRe_q[loadIdx] <= in_re_i;
      memIm_q[loadIdx] <= in_im_i;
    end else if (doButterfly) begin
      memRe_q[topIdx] <= newTopRe;
      memIm_q[topIdx] <= newTopIm;
      memRe_q[botIdx] <= newBotRe;
      memIm_q[botIdx] <= newBotIm;
    end
  end

  assign in_ready_o  = (state_q == LOAD);
  assign out_valid_o = (state_q == UNLOAD);
  assign out_re_o    = out_valid_o ? memRe_q[cnt_q] : '0;
  assign out_im_o    = out_valid_o ? memIm_q[cnt_q] : '0;
  assign out_idx_o   = out_valid_o ? cnt_q : 3'd0;
  assign out_last_o  = out_valid_o && (cnt_q == 3'd7);

endmodule

// File: tb/tb_fantasticfft_ifft8_stream.sv
// Directed bench for the streaming IFFT8: impulse, DC, single-tone,
// backpressure, mid-frame reset and back-to-back frame timing.
module tb_fantasticfft_ifft8_stream;

  logic              clk;
  logic              rst;
  logic              inValid;
  logic              inReady;
  logic signed [7:0] inRe;
  logic signed [7:0] inIm;
  logic              outValid;
  logic              outReady;
  logic signed [7:0] outRe;
  logic signed [7:0] outIm;
  logic [2:0]        outIdx;
  logic              outLast;

  int checks = 0;
  int errors = 0;

  // input frame to send and the expected natural-order output frame
  int vecRe [8];
  int vecIm [8];
  int expRe [8];
  int expIm [8];

  fantasticfft_ifft8_stream #(.DATA_W(8), .TW_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_re_i     (inRe),
    .in_im_i     (inIm),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_re_o    (outRe),
    .out_im_o    (outIm),
    .out_idx_o   (outIdx),
    .out_last_o  (outLast)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hard time limit so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // one comparison: count it, and on a miss count the error and report it
  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // drive the first count samples of vecRe/vecIm, one per clock; returns #1 after the last accepting edge
  task automatic applyStimulus(input int count);
    for (int n = 0; n < count; n++) begin
      inValid = 1'b1;
      inRe    = 8'(vecRe[n]);
      inIm    = 8'(vecIm[n]);
      checkOutput($sformatf("in_ready_load[%0d]", n), inReady, 1);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    inRe    = '0;
    inIm    = '0;
  endtask

  // collect one output frame against expRe/expIm, optionally stalling 5 cycles at stallIdx
  task automatic checkFrame(input int stallIdx);
    int waitCycles;
    waitCycles = 0;
    outReady   = 1'b1;
    while (outValid !== 1'b1 && waitCycles < 40) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("out_valid_arrives", outValid, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("idx[%0d]", i), outIdx, i);
      checkOutput($sformatf("re[%0d]", i), outRe, expRe[i]);
      checkOutput($sformatf("im[%0d]", i), outIm, expIm[i]);
      checkOutput($sformatf("last[%0d]", i), outLast, (i == 7) ? 1 : 0);
      checkOutput($sformatf("in_ready_unload[%0d]", i), inReady, 0);
      if (i == stallIdx) begin
        outReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk);
          #1;
          checkOutput($sformatf("stall_valid[%0d]", c), outValid, 1);
          checkOutput($sformatf("stall_idx[%0d]", c), outIdx, i);
          checkOutput($sformatf("stall_re[%0d]", c), outRe, expRe[i]);
          checkOutput($sformatf("stall_im[%0d]", c), outIm, expIm[i]);
        end
        outReady = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("in_ready_after_last", inReady, 1);
    checkOutput("out_valid_after_last", outValid, 0);
    outReady = 1'b0;
  endtask

  // directed sequence
  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inRe     = '0;
    inIm     = '0;
    outReady = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_out_re", outRe, 0);
    checkOutput("rst_out_im", outIm, 0);
    checkOutput("rst_out_idx", outIdx, 0);
    checkOutput("rst_out_last", outLast, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // impulse, with exact COMPUTE latency and garbage on in_valid during COMPUTE
    vecRe = '{64, 0, 0, 0, 0, 0, 0, 0};
    vecIm = '{default: 0};
    expRe = '{8, 8, 8, 8, 8, 8, 8, 8};
    expIm = '{default: 0};
    applyStimulus(8);
    checkOutput("in_ready_compute", inReady, 0);
    inValid = 1'b1;
    inRe    = 8'sd99;
    inIm    = -8'sd77;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("out_valid_edge12", outValid, 0);
    checkOutput("in_ready_edge12", inReady, 0);
    inValid = 1'b0;
    inRe    = '0;
    inIm    = '0;
    @(posedge clk);
    #1;
    checkOutput("out_valid_edge13", outValid, 1);
    checkFrame(-1);

    // DC, sent back-to-back
    vecRe = '{default: 64};
    vecIm = '{default: 0};
    expRe = '{64, 0, 0, 0, 0, 0, 0, 0};
    expIm = '{default: 0};
    applyStimulus(8);
    checkFrame(-1);

    // single tone on x1
    vecRe = '{0, 64, 0, 0, 0, 0, 0, 0};
    vecIm = '{default: 0};
    expRe = '{8, 5, 0, -6, -8, -6, 0, 5};
    expIm = '{0, 5, 8, 5, 0, -6, -8, -6};
    applyStimulus(8);
    checkFrame(-1);

    // same tone with out_ready held low for 5 cycles at index 3
    applyStimulus(8);
    checkFrame(3);

    // reset after 3 accepted samples discards the partial frame
    vecRe = '{11, 22, 33, 44, 55, 66, 77, 88};
    vecIm = '{-5, -6, -7, -8, -9, -10, -11, -12};
    applyStimulus(3);
    rst = 1'b1;
    #2;
    checkOutput("midrst_in_ready", inReady, 1);
    checkOutput("midrst_out_valid", outValid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vecRe = '{64, 0, 0, 0, 0, 0, 0, 0};
    vecIm = '{default: 0};
    expRe = '{8, 8, 8, 8, 8, 8, 8, 8};
    expIm = '{default: 0};
    applyStimulus(8);
    checkFrame(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
